pwl_act_pipe: RTL and testbench
===============================

// Module: pwl_act_pipe
// PURPOSE
//  Multi-lane, mode-selectable piecewise-linear activation unit (sigmoid / tanh) with valid/ready flow control.
//  Each lane folds x to |x|, looks up one of SEGS/2 slope/intercept segments, then reconstructs the odd/even symmetry.
//  Sits between the MAC array output and the activation writeback buffer. Lanes run in lock-step.
// PARAMETERS
//  WIDTH    16    signed fixed-point word width (x and y)
//  FP       12    fractional bits; ONE = 1<<FP
//  SEGS     8     total segments over [-XMAX,XMAX]; even, >=2; SEGS/2 segments per half
//  BP_STEP  6144  segment width in FP units (1.5); XMAX = BP_STEP*SEGS/2
//  LANES    4     parallel lanes
//  TAGW     4     sideband tag width, passed through unchanged
// PORTS
//  clk        in   1            clock
//  rst        in   1            asynchronous reset, active-high
//  in_valid   in   1            input beat valid
//  in_ready   out  1            unit accepts a beat this cycle
//  in_mode    in   1            0 = sigmoid, 1 = tanh (per beat, applies to all lanes)
//  in_tag     in   TAGW         sideband tag
//  in_x       in   LANES*WIDTH  signed inputs; lane k = bits [k*WIDTH +: WIDTH]
//  out_valid  out  1            output beat valid
//  out_ready  in   1            downstream accepts
//  out_tag    out  TAGW         tag of the beat on out_y
//  out_y      out  LANES*WIDTH  signed results
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, out_tag and out_y = 0; in_ready = 1 after reset.
//  - Pipeline: 4 stages, one global enable en = !out_valid | out_ready; in_ready = en.
//    Beat accepted when in_valid & in_ready. Unstalled latency: accept at edge N -> out_valid at edge N+4.
//    Throughput: 1 beat/cycle. Bubbles advance while en = 1.
//    While stalled, out_* hold stable and no stage advances.
//  - S1: a = |x|. x = -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1. neg = x<0.
//    seg = largest k with a >= k*BP_STEP (a boundary belongs to the upper segment); sat = (a >= XMAX).
//  - S2: p = a * slope[mode][seg], 2*WIDTH signed.
//  - S3: f = (p >>> FP) + icpt[mode][seg], arithmetic floor shift; sat forces f = ONE.
//  - S4: sigmoid: y = neg ? ONE-f : f. tanh: y = neg ? -f : f. Result clamped to [-ONE, ONE].
//    x = 0 takes the positive path.
//  - Mode and tag travel with the beat; consecutive beats of different modes are legal with no bubble.
//  - Reset mid-operation: all in-flight beats are discarded; no partial output.
//  - Default tables, seg 0..3 over [0,1.5),[1.5,3),[3,4.5),[4.5,6):
//    sigmoid slope {867,369,99,23},  icpt {2048,2796,3603,3946}
//    tanh    slope {2472,246,13,1},  icpt {0,3339,4037,4094}
// CONFIGURATION
//  PWL_COEF_LOAD_EN defined:
//    - Adds ports coef_we(in,1), coef_addr(in,1+clog2(SEGS/2)+1 = {mode,seg,is_icpt}), coef_wdata(in,WIDTH), coef_ack(out,1).
//    - Coefficients live in registers, reset to the default tables.
//    - A write is performed and coef_ack pulses high for 1 cycle only when no stage or output holds a valid beat and in_valid = 0.
//      Otherwise the write is dropped and coef_ack stays 0. The new value applies to beats accepted after the write edge.
//  PWL_COEF_LOAD_EN undefined: the ports are absent; coefficients are constants from the package.
// STRUCTURE
//  pwl_act_pkg: MODE_SIGMOID/MODE_TANH constants, ONE, default slope/intercept tables, table address layout.
//  pwl_act_lane: one lane's S1-S4 datapath with an enable input; instantiated LANES times.
//  Top level owns the valid/tag/mode chain, the enable, and the optional coefficient register file.
// TESTING
//  1. sigmoid, all lanes x=0, out_ready=1 -> out_valid 4 cycles after accept, y=2048 in every lane.
//  2. sigmoid x={6144,-6144,24576,-32768} -> y={3349,747,4096,0}; tanh same x -> {3708,-3708,4096,-4096}.
//  3. Stream 16 beats, toggle out_ready 1/0 every 3 cycles -> no beat lost/duplicated, tags in order, out_y stable while stalled.
//  4. Alternating modes, back-to-back beats, x=3072 -> sigmoid 2698 / tanh 1854, no bubble inserted.
//  5. Assert rst with 3 beats in flight -> out_valid=0 next cycle; first post-reset beat emerges with correct value only.
//  6. PWL_COEF_LOAD_EN: idle write sigmoid seg0 slope=0 -> coef_ack=1, x=1000 -> 2048. Write while busy -> coef_ack=0, table unchanged.

Source files
------------

// File: rtl/pwl_act_pkg.sv
// rtl/pwl_act_pkg.sv - shared constants and default PWL coefficient tables for pwl_act_pipe
package pwl_act_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_FP      = 12;
  localparam int DEF_SEGS    = 8;
  localparam int DEF_BP_STEP = 6144;
  localparam int DEF_LANES   = 4;
  localparam int DEF_TAGW    = 4;

  localparam logic MODE_SIGMOID = 1'b0;
  localparam logic MODE_TANH    = 1'b1;

  localparam int ONE = 1 << DEF_FP;

  // Coefficient address layout: {mode, seg, is_icpt}
  localparam int DEF_SEGW   = (DEF_SEGS / 2 > 1) ? $clog2(DEF_SEGS / 2) : 1;
  localparam int COEF_ADDRW = DEF_SEGW + 2;

  function automatic int def_coef(input logic mode, input int seg, input logic is_icpt);
    case ({mode, is_icpt})
      2'b00: case (seg) 0: return 867;  1: return 369;  2: return 99;   3: return 23;   default: return 0; endcase
      2'b01: case (seg) 0: return 2048; 1: return 2796; 2: return 3603; 3: return 3946; default: return 0; endcase
      2'b10: case (seg) 0: return 2472; 1: return 246;  2: return 13;   3: return 1;    default: return 0; endcase
      default: case (seg) 0: return 0;  1: return 3339; 2: return 4037; 3: return 4094; default: return 0; endcase
    endcase
  endfunction

endpackage

// File: rtl/pwl_act_pipe_if.sv
// rtl/pwl_act_pipe_if.sv - beat handshake bundle for pwl_act_pipe
// Coefficient write signals exist only when PWL_COEF_LOAD_EN is defined.
interface pwl_act_pipe_if
  import pwl_act_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int TAGW  = DEF_TAGW
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [TAGW-1:0]        in_tag;
  logic [LANES*WIDTH-1:0] in_x;
  logic                   out_valid;
  logic                   out_ready;
  logic [TAGW-1:0]        out_tag;
  logic [LANES*WIDTH-1:0] out_y;

`ifdef PWL_COEF_LOAD_EN
  logic                  coef_we;
  logic [COEF_ADDRW-1:0] coef_addr;
  logic [WIDTH-1:0]      coef_wdata;
  logic                  coef_ack;

  modport master (
    output in_valid, in_mode, in_tag, in_x, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_tag, out_y, coef_ack
  );
  modport slave (
    input  in_valid, in_mode, in_tag, in_x, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_tag, out_y, coef_ack
  );
`else
  modport master (
    output in_valid, in_mode, in_tag, in_x, out_ready,
    input  in_ready, out_valid, out_tag, out_y
  );
  modport slave (
    input  in_valid, in_mode, in_tag, in_x, out_ready,
    output in_ready, out_valid, out_tag, out_y
  );
`endif

endinterface

// File: rtl/pwl_act_lane.sv
// rtl/pwl_act_lane.sv - one lane of the PWL activation datapath
// Fold to |x|, segment slope multiply, intercept add, symmetry restore and clamp.
module pwl_act_lane
  import pwl_act_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FP      = DEF_FP,
  parameter int SEGS    = DEF_SEGS,
  parameter int BP_STEP = DEF_BP_STEP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic                    i_mode1,
  input  logic                    i_mode2,
  input  logic                    i_mode3,
  input  logic [SEGS*WIDTH-1:0]   i_slope,
  input  logic [SEGS*WIDTH-1:0]   i_icpt,
  output logic signed [WIDTH-1:0] o_y
);

  localparam int HALF = SEGS / 2;
  localparam int SEGW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int XMAX = BP_STEP * HALF;
  localparam logic [WIDTH-1:0]     MIN_X  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     MAX_A  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] ONE_P  = PW'(1 << FP);
  localparam logic signed [PW-1:0] NONE_P = -ONE_P;

  logic [WIDTH-1:0]         w_a;
  logic                     w_neg;
  logic                     w_sat;
  logic [SEGW-1:0]          w_seg;
  logic signed [WIDTH-1:0]  w_slope;
  logic signed [WIDTH-1:0]  w_icpt;
  logic signed [PW-1:0]     w_p;
  logic signed [PW-1:0]     w_f;
  logic signed [PW-1:0]     w_y;

  logic [WIDTH-1:0]         r1_a;
  logic                     r1_neg;
  logic                     r1_sat;
  logic [SEGW-1:0]          r1_seg;
  logic signed [PW-1:0]     r2_p;
  logic                     r2_neg;
  logic                     r2_sat;
  logic [SEGW-1:0]          r2_seg;
  logic signed [PW-1:0]     r3_f;
  logic                     r3_neg;
  logic signed [WIDTH-1:0]  r4_y;

  // Most-negative input has no positive twin, so it saturates to the largest magnitude.
  always_comb begin
    w_neg = i_x[WIDTH-1];
    if (i_x == MIN_X)
      w_a = MAX_A;
    else if (w_neg)
      w_a = ~i_x + WIDTH'(1);
    else
      w_a = i_x;
    w_sat = (32'(w_a) >= 32'(XMAX));
    w_seg = '0;
    for (int k = 1; k < HALF; k++) begin
      if (32'(w_a) >= 32'(k * BP_STEP))
        w_seg = SEGW'(k);
    end
  end

  always_comb begin
    w_slope = i_slope[(int'(i_mode1) * HALF + int'(r1_seg)) * WIDTH +: WIDTH];
    w_p     = PW'($signed(r1_a)) * PW'(w_slope);
  end

  always_comb begin
    w_icpt = i_icpt[(int'(i_mode2) * HALF + int'(r2_seg)) * WIDTH +: WIDTH];
    w_f    = r2_sat ? ONE_P : (r2_p >>> FP) + PW'(w_icpt);
  end

  always_comb begin
    if (!r3_neg)
      w_y = r3_f;
    else if (i_mode3 == MODE_SIGMOID)
      w_y = ONE_P - r3_f;
    else
      w_y = -r3_f;
    if (w_y > ONE_P)
      w_y = ONE_P;
    else if (w_y < NONE_P)
      w_y = NONE_P;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_a   <= '0;
      r1_neg <= 1'b0;
      r1_sat <= 1'b0;
      r1_seg <= '0;
      r2_p   <= '0;
      r2_neg <= 1'b0;
      r2_sat <= 1'b0;
      r2_seg <= '0;
      r3_f   <= '0;
      r3_neg <= 1'b0;
      r4_y   <= '0;
    end else if (i_en) begin
      r1_a   <= w_a;
      r1_neg <= w_neg;
      r1_sat <= w_sat;
      r1_seg <= w_seg;
      r2_p   <= w_p;
      r2_neg <= r1_neg;
      r2_sat <= r1_sat;
      r2_seg <= r1_seg;
      r3_f   <= w_f;
      r3_neg <= r2_neg;
      r4_y   <= WIDTH'(w_y);
    end
  end

  assign o_y = r4_y;

endmodule

// File: rtl/pwl_act_pipe.sv
// rtl/pwl_act_pipe.sv - multi-lane PWL sigmoid/tanh pipeline with valid/ready flow control
// Optional runtime coefficient registers under PWL_COEF_LOAD_EN.
module pwl_act_pipe
  import pwl_act_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FP      = DEF_FP,
  parameter int SEGS    = DEF_SEGS,
  parameter int BP_STEP = DEF_BP_STEP,
  parameter int LANES   = DEF_LANES,
  parameter int TAGW    = DEF_TAGW
) (
  input  logic          clk,
  input  logic          rst,
  pwl_act_pipe_if.slave bus
);

  localparam int HALF = SEGS / 2;
  localparam int SEGW = (HALF > 1) ? $clog2(HALF) : 1;

  logic                   w_en;
  logic [SEGS*WIDTH-1:0]  w_slope_tbl;
  logic [SEGS*WIDTH-1:0]  w_icpt_tbl;
  logic [LANES*WIDTH-1:0] w_y;

  logic                   r_v0, r_v1, r_v2, r_v3, r_out_valid;
  logic                   r_mode0, r_mode1, r_mode2, r_mode3;
  logic [TAGW-1:0]        r_tag0, r_tag1, r_tag2, r_tag3, r_out_tag;
  logic [LANES*WIDTH-1:0] r_x0;

  assign w_en          = !r_out_valid || bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_y     = w_y;

  // Capture stage ahead of S1 gives accept-to-output latency of four edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_out_valid <= 1'b0;
      r_mode0     <= MODE_SIGMOID;
      r_mode1     <= MODE_SIGMOID;
      r_mode2     <= MODE_SIGMOID;
      r_mode3     <= MODE_SIGMOID;
      r_tag0      <= '0;
      r_tag1      <= '0;
      r_tag2      <= '0;
      r_tag3      <= '0;
      r_out_tag   <= '0;
      r_x0        <= '0;
    end else if (w_en) begin
      r_v0        <= bus.in_valid;
      r_v1        <= r_v0;
      r_v2        <= r_v1;
      r_v3        <= r_v2;
      r_out_valid <= r_v3;
      r_mode0     <= bus.in_mode;
      r_mode1     <= r_mode0;
      r_mode2     <= r_mode1;
      r_mode3     <= r_mode2;
      r_tag0      <= bus.in_tag;
      r_tag1      <= r_tag0;
      r_tag2      <= r_tag1;
      r_tag3      <= r_tag2;
      r_out_tag   <= r_tag3;
      r_x0        <= bus.in_x;
    end
  end

`ifdef PWL_COEF_LOAD_EN
  logic [WIDTH-1:0] r_slope [SEGS];
  logic [WIDTH-1:0] r_icpt  [SEGS];
  logic             r_coef_ack;
  logic             w_idle;
  logic             w_coef_wr;
  logic [SEGW:0]    w_cidx;

  // Writes are only safe when no beat could observe a half-updated table.
  assign w_idle    = !(r_v0 || r_v1 || r_v2 || r_v3 || r_out_valid || bus.in_valid);
  assign w_coef_wr = bus.coef_we && w_idle;
  assign w_cidx    = bus.coef_addr[SEGW+1:1];
  assign bus.coef_ack = r_coef_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coef_ack <= 1'b0;
      for (int i = 0; i < SEGS; i++) begin
        r_slope[i] <= WIDTH'(def_coef(i >= HALF, i % HALF, 1'b0));
        r_icpt[i]  <= WIDTH'(def_coef(i >= HALF, i % HALF, 1'b1));
      end
    end else begin
      r_coef_ack <= w_coef_wr;
      if (w_coef_wr) begin
        if (bus.coef_addr[0])
          r_icpt[w_cidx] <= bus.coef_wdata;
        else
          r_slope[w_cidx] <= bus.coef_wdata;
      end
    end
  end

  always_comb begin
    w_slope_tbl = '0;
    w_icpt_tbl  = '0;
    for (int i = 0; i < SEGS; i++) begin
      w_slope_tbl[i*WIDTH +: WIDTH] = r_slope[i];
      w_icpt_tbl[i*WIDTH +: WIDTH]  = r_icpt[i];
    end
  end
`else
  always_comb begin
    w_slope_tbl = '0;
    w_icpt_tbl  = '0;
    for (int i = 0; i < SEGS; i++) begin
      w_slope_tbl[i*WIDTH +: WIDTH] = WIDTH'(def_coef(i >= HALF, i % HALF, 1'b0));
      w_icpt_tbl[i*WIDTH +: WIDTH]  = WIDTH'(def_coef(i >= HALF, i % HALF, 1'b1));
    end
  end
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pwl_act_lane #(
      .WIDTH   (WIDTH),
      .FP      (FP),
      .SEGS    (SEGS),
      .BP_STEP (BP_STEP)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_x     (r_x0[k*WIDTH +: WIDTH]),
      .i_mode1 (r_mode1),
      .i_mode2 (r_mode2),
      .i_mode3 (r_mode3),
      .i_slope (w_slope_tbl),
      .i_icpt  (w_icpt_tbl),
      .o_y     (w_y[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// tb/tb_pwl_act_pipe.sv - directed self-checking bench for pwl_act_pipe
// Coefficient-write steps are included when PWL_COEF_LOAD_EN is defined.
module tb_pwl_act_pipe;
  import pwl_act_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int L = DEF_LANES;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pwl_act_pipe_if #(.WIDTH(W), .LANES(L), .TAGW(DEF_TAGW)) bus ();

  pwl_act_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] lane_y(input int k);
    logic signed [W-1:0] t;
    t = bus.out_y[k*W +: W];
    return t;
  endfunction

  task automatic drive(input logic mode, input int tag, input int x0, input int x1, input int x2, input int x3);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_tag   = tag[DEF_TAGW-1:0];
    bus.in_x     = {x3[W-1:0], x2[W-1:0], x1[W-1:0], x0[W-1:0]};
  endtask

  task automatic send(input logic mode, input int tag, input int x0, input int x1, input int x2, input int x3);
    drive(mode, tag, x0, x1, x2, x3);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_beat(input string name, input int tag, input int e0, input int e1, input int e2, input int e3);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, ".valid"}, bus.out_valid, 1);
    check({name, ".tag"}, bus.out_tag, tag);
    check({name, ".y0"}, lane_y(0), e0);
    check({name, ".y1"}, lane_y(1), e1);
    check({name, ".y2"}, lane_y(2), e2);
    check({name, ".y3"}, lane_y(3), e3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    int c;
    int cyc;
    logic stall;
    logic [L*W-1:0] held_y;
    logic [DEF_TAGW-1:0] held_tag;
    int sig_e [4];
    int tanh_e [4];
    sig_e  = '{3349, 747, 4096, 0};
    tanh_e = '{3708, -3708, 4096, -4096};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = MODE_SIGMOID;
    bus.in_tag    = '0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
`ifdef PWL_COEF_LOAD_EN
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_y", bus.out_y, 0);
    check("rst.out_tag", bus.out_tag, 0);

    // zero input, latency
    drive(MODE_SIGMOID, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t1.lat3", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("t1.lat4", bus.out_valid, 1);
    expect_beat("t1", 1, ONE / 2, ONE / 2, ONE / 2, ONE / 2);

    // boundary, saturation, most-negative input
    send(MODE_SIGMOID, 2, 6144, -6144, 24576, -32768);
    expect_beat("t2s", 2, 3349, 747, 4096, 0);
    send(MODE_TANH, 3, 6144, -6144, 24576, -32768);
    expect_beat("t2t", 3, 3708, -3708, 4096, -4096);

    // alternating modes back to back
    for (int i = 0; i < 4; i++) begin
      drive((i % 2 == 1) ? MODE_TANH : MODE_SIGMOID, 4 + i, 3072, 3072, 3072, 3072);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t4.valid", bus.out_valid, 1);
      check("t4.tag", bus.out_tag, 4 + i);
      check("t4.y0", lane_y(0), (i % 2 == 1) ? 1854 : 2698);
      check("t4.y3", lane_y(3), (i % 2 == 1) ? 1854 : 2698);
      @(posedge clk);
      #1;
    end

    // streaming with back-pressure
    p = 0;
    c = 0;
    cyc = 0;
    stall = 1'b0;
    held_y = '0;
    held_tag = '0;
    while (c < 16 && cyc < 300) begin
      @(posedge clk);
      #1;
      if (stall) begin
        check("t3.hold_y", bus.out_y, held_y);
        check("t3.hold_tag", bus.out_tag, held_tag);
      end
      bus.out_ready = ((cyc / 3) % 2 == 0);
      if (p < 16)
        drive((p % 2 == 1) ? MODE_TANH : MODE_SIGMOID, p, 6144, -6144, 24576, -32768);
      else
        bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        check("t3.tag", bus.out_tag, c);
        for (int k = 0; k < 4; k++)
          check("t3.y", lane_y(k), (c % 2 == 1) ? tanh_e[k] : sig_e[k]);
        c++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1)
        p++;
      stall    = (bus.out_valid === 1'b1) && !bus.out_ready;
      held_y   = bus.out_y;
      held_tag = bus.out_tag;
      cyc++;
    end
    check("t3.count", c, 16);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      drive(MODE_SIGMOID, 8 + i, 3072, 3072, 3072, 3072);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5.async", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("t5.next", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("t5.quiet", bus.out_valid, 0);
    end
    send(MODE_TANH, 11, 3072, 3072, 3072, 3072);
    expect_beat("t5", 11, 1854, 1854, 1854, 1854);
    @(posedge clk);
    #1;
    check("t5.single", bus.out_valid, 0);

`ifdef PWL_COEF_LOAD_EN
    repeat (6) @(posedge clk);
    #1;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    check("t6.ack_idle", bus.coef_ack, 1);
    @(posedge clk);
    #1;
    check("t6.ack_pulse", bus.coef_ack, 0);
    send(MODE_SIGMOID, 12, 1000, 1000, 1000, 1000);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = 16'd500;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    check("t6.ack_busy", bus.coef_ack, 0);
    expect_beat("t6a", 12, 2048, 2048, 2048, 2048);
    @(posedge clk);
    #1;
    send(MODE_SIGMOID, 13, 1000, 1000, 1000, 1000);
    expect_beat("t6b", 13, 2048, 2048, 2048, 2048);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
